// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner
// Upstream conditioner for the vending-machine FSM. Each coin sensor is
// synchronised (two flops) and debounced by a four-state FSM
// (IDLE/PRESS/HELD/RELEASE). Every physical coin yields exactly one
// single-cycle pulse on R or C, never both in the same cycle. One coin per
// channel can be queued while downstream asserts hold.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   coin_r_raw  raw 1-real sensor level (async)
//   coin_c_raw  raw 50-cent sensor level (async)
//   hold        downstream busy; pulses suppressed, queued coins kept
//   R           registered pulse, one 1-real coin accepted
//   C           registered pulse, one 50-cent coin accepted
//   ovf         sticky, a coin was dropped on a full channel queue
//   jam_r       1-real channel jammed (JAM_DETECT_EN only, else 0)
//   jam_c       50-cent channel jammed (JAM_DETECT_EN only, else 0)
//
// Optional feature macro: JAM_DETECT_EN (jam counters per channel).
module coin_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int JAM_CYCLES      = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_r_raw,
  input  logic coin_c_raw,
  input  logic hold,
  output logic R,
  output logic C,
  output logic ovf,
  output logic jam_r,
  output logic jam_c
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Channel 0 is the 1-real slot, channel 1 the 50-cent slot.
  logic [1:0] raw;
  logic [1:0] accept;
  logic [1:0] jam;

  assign raw = {coin_c_raw, coin_r_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic        meta;
    logic        sync;
    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        acc;

    // Two-flop synchroniser for the asynchronous sensor level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta <= 1'b0;
        sync <= 1'b0;
      end else begin
        meta <= raw[ch];
        sync <= meta;
      end
    end

    // Debounce FSM state and counter register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= RELEASE;
        cnt   <= 16'd0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    // Debounce FSM next-state; acc marks the single PRESS->HELD transition.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      acc       = 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state_nxt = PRESS;
            cnt_nxt   = 16'd0;
          end else begin
            state_nxt = IDLE;
          end
        end
        PRESS: begin
          if (!sync) begin
            state_nxt = IDLE;
          end else if (cnt == CNT_LAST) begin
            state_nxt = HELD;
            acc       = 1'b1;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        HELD: begin
          if (!sync) begin
            state_nxt = RELEASE;
            cnt_nxt   = 16'd0;
          end else begin
            state_nxt = HELD;
          end
        end
        RELEASE: begin
          // A bounce back high re-enters HELD without a new coin event.
          if (sync) begin
            state_nxt = HELD;
          end else if (cnt == CNT_LAST) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        default: begin
          state_nxt = RELEASE;
          cnt_nxt   = 16'd0;
        end
      endcase
    end

    assign accept[ch] = acc;

`ifdef JAM_DETECT_EN
    localparam int            JW       = $clog2(JAM_CYCLES) + 1;
    localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);

    logic [JW-1:0] jam_cnt;
    logic [JW-1:0] jam_cnt_nxt;
    logic          jam_q;

    // Saturating HELD-duration counter; restarts on every HELD entry.
    always_comb begin
      jam_cnt_nxt = jam_cnt;
      if (state_nxt != HELD) begin
        jam_cnt_nxt = {JW{1'b0}};
      end else if (state != HELD) begin
        jam_cnt_nxt = {JW{1'b0}};
      end else if (jam_cnt != JAM_LAST) begin
        jam_cnt_nxt = jam_cnt + {{(JW-1){1'b0}}, 1'b1};
      end else begin
        jam_cnt_nxt = jam_cnt;
      end
    end

    // Jam counter and flag; flag drops on the edge the FSM leaves HELD.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        jam_cnt <= {JW{1'b0}};
        jam_q   <= 1'b0;
      end else begin
        jam_cnt <= jam_cnt_nxt;
        jam_q   <= (state_nxt == HELD) && (jam_cnt_nxt == JAM_LAST);
      end
    end

    assign jam[ch] = jam_q;
`else
    assign jam[ch] = 1'b0;
`endif
  end

`ifndef JAM_DETECT_EN
  // JAM_CYCLES only shapes the jam counters, which are absent in this build.
  logic unused_jam_cfg;
  assign unused_jam_cfg = ^JAM_CYCLES;
`endif

  assign jam_r = jam[0];
  assign jam_c = jam[1];

  logic pend_r;
  logic pend_c;
  logic pend_r_nxt;
  logic pend_c_nxt;
  logic cons_r;
  logic cons_c;
  logic drop_r;
  logic drop_c;

  // Queue bookkeeping: R has priority, so C is only consumed when pend_r
  // is empty. A consume and a new accept on the same edge keep the flag set.
  always_comb begin
    cons_r = !hold && pend_r;
    cons_c = !hold && !pend_r && pend_c;
    drop_r = accept[0] && pend_r && !cons_r;
    drop_c = accept[1] && pend_c && !cons_c;
    if (accept[0]) begin
      pend_r_nxt = 1'b1;
    end else if (cons_r) begin
      pend_r_nxt = 1'b0;
    end else begin
      pend_r_nxt = pend_r;
    end
    if (accept[1]) begin
      pend_c_nxt = 1'b1;
    end else if (cons_c) begin
      pend_c_nxt = 1'b0;
    end else begin
      pend_c_nxt = pend_c;
    end
  end

  // Pending flags, output pulses and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= 1'b0;
      pend_c <= 1'b0;
      R      <= 1'b0;
      C      <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      pend_r <= pend_r_nxt;
      pend_c <= pend_c_nxt;
      R      <= cons_r;
      C      <= cons_c;
      ovf    <= ovf || drop_r || drop_c;
    end
  end

endmodule

// File: tb/tb_coin_input_conditioner.sv
module tb_coin_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin_r_raw = 1'b0;
  logic coin_c_raw = 1'b0;
  logic hold = 1'b0;
  logic R, C, ovf, jam_r, jam_c;

  int checks = 0;
  int passes = 0;

  coin_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .JAM_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .coin_r_raw(coin_r_raw),
    .coin_c_raw(coin_c_raw),
    .hold(hold),
    .R(R),
    .C(C),
    .ovf(ovf),
    .jam_r(jam_r),
    .jam_c(jam_c)
  );

  always #5 clk = ~clk;

  // One record per clock: inputs driven before the edge, outputs expected after it.
  typedef struct {
    logic r;
    logic c;
    logic h;
    logic er;
    logic ec;
    logic eo;
    logic ejr;
    logic ejc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic got, input logic want);
    checks++;
    if (got === want) begin
      passes++;
    end else begin
      $display("FAIL %s[%0d] got %0b want %0b", name, idx, got, want);
    end
  endtask

  task automatic add(input logic r, input logic c, input logic h,
                     input logic er, input logic ec, input logic eo,
                     input logic ejr, input logic ejc, input int n);
    vec_t v;
    v.r = r; v.c = c; v.h = h;
    v.er = er; v.ec = ec; v.eo = eo; v.ejr = ejr; v.ejc = ejc;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic run(input string seg);
    for (int i = 0; i < vecs.size(); i++) begin
      coin_r_raw = vecs[i].r;
      coin_c_raw = vecs[i].c;
      hold       = vecs[i].h;
      @(posedge clk);
      #1;
      chk({seg, ".R"}, i, R, vecs[i].er);
      chk({seg, ".C"}, i, C, vecs[i].ec);
      chk({seg, ".ovf"}, i, ovf, vecs[i].eo);
      chk({seg, ".jam_r"}, i, jam_r, vecs[i].ejr);
      chk({seg, ".jam_c"}, i, jam_c, vecs[i].ejc);
    end
    vecs.delete();
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst.R", 0, R, 1'b0);
    chk("rst.C", 0, C, 1'b0);
    chk("rst.ovf", 0, ovf, 1'b0);
    chk("rst.jam_r", 0, jam_r, 1'b0);
    chk("rst.jam_c", 0, jam_c, 1'b0);
    rst = 1'b0;

    // Leave RELEASE for IDLE with both sensors low.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    run("settle");

    // Single 1-real coin, high 20 cycles: R at the 8th edge (e0+7) only.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    run("coin_r");

    // 2-cycle glitch on the 50-cent sensor: no pulse, no overflow.
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    run("glitch_c");

    // Simultaneous coins: R at e0+7, C at e0+8, never together.
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    run("both");

    // Two r coins under hold: second accept (7th edge of its press) sets ovf;
    // one R pulse on the first edge after hold drops.
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6);
    run("hold_ovf");

    // Sensor held high across an asynchronous reset pulse.
    coin_r_raw = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst.ovf", 0, ovf, 1'b0);
    chk("async_rst.R", 0, R, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    run("held_thru_rst");

`ifdef JAM_DETECT_EN
    // 50-cent held 60 cycles: HELD entered at the 7th edge, jam_c set 31
    // edges later (38th), cleared on the 3rd edge after the sensor drops.
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 29);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 23);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);
    run("jam_c");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
